reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 164 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: results complete out of order and retire in order from the head.
// A mispredicted branch at commit clears every entry and emits a one-cycle redirect.
module reorder_buffer #(
  parameter int ROB_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        alloc_valid,
  input  logic [4:0]  alloc_rd,
  input  logic        alloc_br,
  input  logic        alloc_pred,
  input  logic [31:0] alloc_alt_addr,
  output logic [3:0]  alloc_tag,
  output logic        full,
  input  logic        submit_valid,
  input  logic [3:0]  submit_tag,
  input  logic [31:0] submit_val,
  input  logic        cdb_active,
  input  logic [3:0]  cdb_tag,
  input  logic [31:0] cdb_val,
  input  logic [3:0]  q1_tag,
  input  logic [3:0]  q2_tag,
  output logic        q1_ready,
  output logic [31:0] q1_val,
  output logic        q2_ready,
  output logic [31:0] q2_val,
  output logic        commit_valid,
  output logic [4:0]  commit_rd,
  output logic [31:0] commit_val,
  output logic [3:0]  commit_tag,
  output logic        flush_out,
  output logic [31:0] flush_addr
);
  localparam int PW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam logic [3:0]    DEPTH4 = 4'(ROB_DEPTH);
  localparam logic [PW-1:0] LAST   = PW'(ROB_DEPTH - 1);

  logic          w_busy  [ROB_DEPTH];
  logic          w_ready [ROB_DEPTH];
  logic          w_br    [ROB_DEPTH];
  logic          w_pred  [ROB_DEPTH];
  logic [4:0]    w_rd    [ROB_DEPTH];
  logic [31:0]   w_val   [ROB_DEPTH];
  logic [31:0]   w_alt   [ROB_DEPTH];

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [3:0]    r_count;
  logic          r_flush;
  logic [31:0]   r_flush_addr;

  logic          w_full;
  logic          w_alloc;
  logic          w_commit;
  logic          w_mispredict;
  logic [PW-1:0] w_head_nxt;
  logic [PW-1:0] w_tail_nxt;

  assign w_full       = (r_count == DEPTH4);
  assign w_alloc      = alloc_valid && !w_full;
  assign w_commit     = w_busy[r_head] && w_ready[r_head];
  assign w_mispredict = w_commit && w_br[r_head] && (w_val[r_head][0] != w_pred[r_head]);
  assign w_head_nxt   = (r_head == LAST) ? '0 : r_head + PW'(1);
  assign w_tail_nxt   = (r_tail == LAST) ? '0 : r_tail + PW'(1);

  assign full         = w_full;
  assign alloc_tag    = w_full ? 4'd0 : 4'(r_tail) + 4'd1;
  assign commit_valid = w_commit;
  assign commit_rd    = (w_commit && !w_br[r_head]) ? w_rd[r_head] : 5'd0;
  assign commit_val   = w_commit ? w_val[r_head] : 32'd0;
  assign commit_tag   = w_commit ? 4'(r_head) + 4'd1 : 4'd0;
  assign flush_out    = r_flush;
  assign flush_addr   = r_flush_addr;

  // Each entry owns its storage; a clear (commit or flush) beats any completion.
  for (genvar g = 0; g < ROB_DEPTH; g++) begin : g_entry
    logic        r_busy, r_ready, r_br, r_pred;
    logic [4:0]  r_rd;
    logic [31:0] r_val, r_alt;
    logic        w_sub_hit, w_cdb_hit, w_clr, w_wr;

    assign w_sub_hit = submit_valid && (submit_tag == 4'(g + 1)) && r_busy;
    assign w_cdb_hit = cdb_active && (cdb_tag == 4'(g + 1)) && r_busy;
    assign w_clr     = w_mispredict || (w_commit && (r_head == PW'(g)));
    assign w_wr      = w_alloc && (r_tail == PW'(g));

    always_ff @(posedge clk_in) begin
      if (rst_in || (rdy_in && w_clr)) begin
        r_busy  <= 1'b0;
        r_ready <= 1'b0;
        r_br    <= 1'b0;
        r_pred  <= 1'b0;
        r_rd    <= 5'd0;
        r_val   <= 32'd0;
        r_alt   <= 32'd0;
      end else if (rdy_in) begin
        if (w_wr) begin
          r_busy  <= 1'b1;
          r_ready <= 1'b0;
          r_br    <= alloc_br;
          r_pred  <= alloc_pred;
          r_rd    <= alloc_rd;
          r_val   <= 32'd0;
          r_alt   <= alloc_alt_addr;
        end else if (w_cdb_hit) begin
          r_val   <= cdb_val;
          r_ready <= 1'b1;
        end else if (w_sub_hit) begin
          r_val   <= submit_val;
          r_ready <= 1'b1;
        end
      end
    end

    assign w_busy[g]  = r_busy;
    assign w_ready[g] = r_ready;
    assign w_br[g]    = r_br;
    assign w_pred[g]  = r_pred;
    assign w_rd[g]    = r_rd;
    assign w_val[g]   = r_val;
    assign w_alt[g]   = r_alt;
  end

  always_comb begin
    q1_ready = 1'b0;
    q1_val   = 32'd0;
    q2_ready = 1'b0;
    q2_val   = 32'd0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if ((q1_tag == 4'(i + 1)) && w_busy[i] && w_ready[i]) begin
        q1_ready = 1'b1;
        q1_val   = w_val[i];
      end
      if ((q2_tag == 4'(i + 1)) && w_busy[i] && w_ready[i]) begin
        q2_ready = 1'b1;
        q2_val   = w_val[i];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= 4'd0;
      r_flush      <= 1'b0;
      r_flush_addr <= 32'd0;
    end else if (rdy_in) begin
      r_flush <= w_mispredict;
      if (w_mispredict) begin
        r_flush_addr <= w_alt[r_head];
        r_head       <= '0;
        r_tail       <= '0;
        r_count      <= 4'd0;
      end else begin
        if (w_commit) r_head <= w_head_nxt;
        if (w_alloc)  r_tail <= w_tail_nxt;
        if (w_alloc && !w_commit)      r_count <= r_count + 4'd1;
        else if (!w_alloc && w_commit) r_count <= r_count - 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner sequences,
// then random traffic checked against a queue-based model of in-order retirement.
module tb_reorder_buffer;
  localparam int D = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        alloc_valid, alloc_br, alloc_pred;
  logic [4:0]  alloc_rd;
  logic [31:0] alloc_alt_addr;
  logic [3:0]  alloc_tag;
  logic        full;
  logic        submit_valid, cdb_active;
  logic [3:0]  submit_tag, cdb_tag, q1_tag, q2_tag;
  logic [31:0] submit_val, cdb_val, q1_val, q2_val;
  logic        q1_ready, q2_ready;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_tag;
  logic        flush_out;
  logic [31:0] flush_addr;

  reorder_buffer #(.ROB_DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_br(alloc_br),
    .alloc_pred(alloc_pred), .alloc_alt_addr(alloc_alt_addr),
    .alloc_tag(alloc_tag), .full(full),
    .submit_valid(submit_valid), .submit_tag(submit_tag), .submit_val(submit_val),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q1_val(q1_val),
    .q2_ready(q2_ready), .q2_val(q2_val),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_tag(commit_tag), .flush_out(flush_out), .flush_addr(flush_addr)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst_in = 1'b0; rdy_in = 1'b1;
    alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_br = 1'b0; alloc_pred = 1'b0; alloc_alt_addr = 32'd0;
    submit_valid = 1'b0; submit_tag = 4'd0; submit_val = 32'd0;
    cdb_active = 1'b0; cdb_tag = 4'd0; cdb_val = 32'd0;
    q1_tag = 4'd0; q2_tag = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic av; logic [4:0] ard; logic abr; logic apred; logic [31:0] aalt;
    logic sv; logic [3:0] stag; logic [31:0] sval;
    logic ca; logic [3:0] ctag; logic [31:0] cval;
    logic [3:0] q1t;
    logic [3:0] e_atag; logic e_cv; logic [4:0] e_crd; logic [31:0] e_cval; logic [3:0] e_ctag;
    logic e_q1r; logic [31:0] e_q1v; logic e_fl; logic [31:0] e_fa;
  } vec_t;

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic abr, input logic apred, input logic [31:0] aalt,
    input logic sv, input logic [3:0] stag, input logic [31:0] sval,
    input logic ca, input logic [3:0] ctag, input logic [31:0] cval, input logic [3:0] q1t,
    input logic [3:0] e_atag, input logic e_cv, input logic [4:0] e_crd, input logic [31:0] e_cval,
    input logic [3:0] e_ctag, input logic e_q1r, input logic [31:0] e_q1v,
    input logic e_fl, input logic [31:0] e_fa);
    vec_t v;
    v.av = av; v.ard = ard; v.abr = abr; v.apred = apred; v.aalt = aalt;
    v.sv = sv; v.stag = stag; v.sval = sval; v.ca = ca; v.ctag = ctag; v.cval = cval; v.q1t = q1t;
    v.e_atag = e_atag; v.e_cv = e_cv; v.e_crd = e_crd; v.e_cval = e_cval; v.e_ctag = e_ctag;
    v.e_q1r = e_q1r; v.e_q1v = e_q1v; v.e_fl = e_fl; v.e_fa = e_fa;
    return v;
  endfunction

  vec_t tbl[$];

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [3:0] tag; logic [4:0] rd; logic br; logic pred;
    logic [31:0] alt; logic [31:0] val; logic rdy;
  } ent_t;

  ent_t        m_q[$];
  int          m_tail;
  logic        m_flush;
  logic [31:0] m_faddr;

  function automatic logic [32:0] lookup(input logic [3:0] t);
    foreach (m_q[i]) if (m_q[i].tag == t && m_q[i].rdy) return {1'b1, m_q[i].val};
    return 33'd0;
  endfunction

  task automatic check_model();
    logic [32:0] l1, l2;
    bit f, cv;
    f  = (m_q.size() == D);
    cv = (m_q.size() > 0) ? m_q[0].rdy : 1'b0;
    check("full", full, f);
    check("alloc_tag", alloc_tag, f ? 32'd0 : 32'(m_tail + 1));
    check("commit_valid", commit_valid, cv);
    if (cv) begin
      check("commit_rd", commit_rd, m_q[0].br ? 32'd0 : 32'(m_q[0].rd));
      check("commit_val", commit_val, m_q[0].val);
      check("commit_tag", commit_tag, m_q[0].tag);
    end else begin
      check("commit_rd", commit_rd, 0);
      check("commit_val", commit_val, 0);
      check("commit_tag", commit_tag, 0);
    end
    l1 = lookup(q1_tag);
    l2 = lookup(q2_tag);
    check("q1_ready", q1_ready, l1[32]);
    check("q1_val", q1_val, l1[31:0]);
    check("q2_ready", q2_ready, l2[32]);
    check("q2_val", q2_val, l2[31:0]);
    check("flush_out", flush_out, m_flush);
    check("flush_addr", flush_addr, m_faddr);
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_edge();
    bit was_full, cm;
    ent_t e;
    if (rst_in) begin
      m_q.delete(); m_tail = 0; m_flush = 1'b0; m_faddr = 32'd0;
      return;
    end
    if (!rdy_in) return;
    was_full = (m_q.size() == D);
    cm = (m_q.size() > 0) ? m_q[0].rdy : 1'b0;
    m_flush = 1'b0;
    if (cm && m_q[0].br && (m_q[0].val[0] != m_q[0].pred)) begin
      m_flush = 1'b1; m_faddr = m_q[0].alt;
      m_q.delete(); m_tail = 0;
      return;
    end
    foreach (m_q[i]) begin
      if (submit_valid && submit_tag == m_q[i].tag) begin m_q[i].val = submit_val; m_q[i].rdy = 1'b1; end
      if (cdb_active && cdb_tag == m_q[i].tag) begin m_q[i].val = cdb_val; m_q[i].rdy = 1'b1; end
    end
    if (cm) void'(m_q.pop_front());
    if (alloc_valid && !was_full) begin
      e.tag = 4'(m_tail + 1); e.rd = alloc_rd; e.br = alloc_br; e.pred = alloc_pred;
      e.alt = alloc_alt_addr; e.val = 32'd0; e.rdy = 1'b0;
      m_q.push_back(e);
      m_tail = (m_tail + 1) % D;
    end
  endtask

  function automatic logic [3:0] pick_tag();
    if (m_q.size() > 0 && $urandom_range(0, 3) != 0) return m_q[$urandom_range(0, m_q.size() - 1)].tag;
    return 4'($urandom_range(0, D + 2));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // av ard abr apred aalt | sv stag sval | ca ctag cval | q1t || atag cv crd cval ctag q1r q1v fl fa
    tbl.push_back(mk(1,5,0,0,0,        0,0,0,        0,0,0,     0, 1,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        1,1,'h1234,   0,0,0,     1, 2,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     1, 2,1,5,'h1234,1,1,'h1234,0,0));
    tbl.push_back(mk(1,7,0,0,0,        0,0,0,        0,0,0,     1, 2,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,8,0,0,0,        0,0,0,        0,0,0,     0, 3,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        1,3,'hA,      1,3,'hB,   0, 4,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        1,2,'h55,  3, 4,0,0,0,0,1,'hB,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     2, 4,1,7,'h55,2,1,'h55,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     0, 4,1,8,'hB,3,0,0,0,0));
    tbl.push_back(mk(1,9,1,1,'h100,    0,0,0,        0,0,0,     3, 4,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        1,4,0,        0,0,0,     0, 5,0,0,0,0,0,0,0,0));
    tbl.push_back(mk(1,3,0,0,0,        0,0,0,        0,0,0,     0, 5,1,0,0,4,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     0, 1,0,0,0,0,0,0,1,'h100));
    tbl.push_back(mk(1,4,1,0,'h200,    0,0,0,        0,0,0,     0, 1,0,0,0,0,0,0,0,'h100));
    tbl.push_back(mk(0,0,0,0,0,        1,1,2,        0,0,0,     0, 2,0,0,0,0,0,0,0,'h100));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     0, 2,1,0,2,1,0,0,0,'h100));
    tbl.push_back(mk(0,0,0,0,0,        0,0,0,        0,0,0,     0, 2,0,0,0,0,0,0,0,'h100));

    idle_inputs();
    do_reset();
    q1_tag = 4'd1; q2_tag = 4'd2;
    @(negedge clk_in);
    check("rst_full", full, 0);
    check("rst_alloc_tag", alloc_tag, 1);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_val", commit_val, 0);
    check("rst_commit_tag", commit_tag, 0);
    check("rst_q1_ready", q1_ready, 0);
    check("rst_q2_ready", q2_ready, 0);
    check("rst_flush_out", flush_out, 0);
    check("rst_flush_addr", flush_addr, 0);
    tick();

    foreach (tbl[i]) begin
      idle_inputs();
      alloc_valid = tbl[i].av; alloc_rd = tbl[i].ard; alloc_br = tbl[i].abr;
      alloc_pred = tbl[i].apred; alloc_alt_addr = tbl[i].aalt;
      submit_valid = tbl[i].sv; submit_tag = tbl[i].stag; submit_val = tbl[i].sval;
      cdb_active = tbl[i].ca; cdb_tag = tbl[i].ctag; cdb_val = tbl[i].cval;
      q1_tag = tbl[i].q1t;
      @(negedge clk_in);
      check($sformatf("tbl%0d_alloc_tag", i), alloc_tag, tbl[i].e_atag);
      check($sformatf("tbl%0d_commit_valid", i), commit_valid, tbl[i].e_cv);
      check($sformatf("tbl%0d_commit_rd", i), commit_rd, tbl[i].e_crd);
      check($sformatf("tbl%0d_commit_val", i), commit_val, tbl[i].e_cval);
      check($sformatf("tbl%0d_commit_tag", i), commit_tag, tbl[i].e_ctag);
      check($sformatf("tbl%0d_q1_ready", i), q1_ready, tbl[i].e_q1r);
      check($sformatf("tbl%0d_q1_val", i), q1_val, tbl[i].e_q1v);
      check($sformatf("tbl%0d_flush_out", i), flush_out, tbl[i].e_fl);
      check($sformatf("tbl%0d_flush_addr", i), flush_addr, tbl[i].e_fa);
      tick();
    end

    // Fill to full, reject allocations while full (including on the commit cycle), then wrap.
    idle_inputs();
    do_reset();
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 10);
      @(negedge clk_in);
      check("fill_alloc_tag", alloc_tag, 32'(i + 1));
      check("fill_full", full, 0);
      tick();
    end
    alloc_valid = 1'b1; alloc_rd = 5'd31;
    submit_valid = 1'b1; submit_tag = 4'd1; submit_val = 32'd7;
    @(negedge clk_in);
    check("full_flag", full, 1);
    check("full_alloc_tag", alloc_tag, 0);
    tick();
    submit_valid = 1'b0;
    @(negedge clk_in);
    check("full_commit_valid", commit_valid, 1);
    check("full_commit_tag", commit_tag, 1);
    check("full_commit_rd", commit_rd, 10);
    check("full_commit_val", commit_val, 7);
    check("full_still_full", full, 1);
    tick();
    alloc_valid = 1'b0;
    @(negedge clk_in);
    check("wrap_full", full, 0);
    check("wrap_alloc_tag", alloc_tag, 1);
    check("wrap_commit_valid", commit_valid, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_valid = 1'b0;
    @(negedge clk_in);
    check("refill_full", full, 1);
    check("refill_alloc_tag", alloc_tag, 0);
    tick();

    // rdy_in low holds everything; reset discards a committable entry silently.
    idle_inputs();
    do_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd2;
    tick();
    alloc_valid = 1'b0; submit_valid = 1'b1; submit_tag = 4'd1; submit_val = 32'd9;
    tick();
    submit_valid = 1'b0; rdy_in = 1'b0; alloc_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_in);
      check("hold_commit_valid", commit_valid, 1);
      check("hold_commit_val", commit_val, 9);
      check("hold_alloc_tag", alloc_tag, 2);
      tick();
    end
    alloc_valid = 1'b0; rdy_in = 1'b1; rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_commit_valid", commit_valid, 0);
    check("midrst_flush_out", flush_out, 0);
    check("midrst_alloc_tag", alloc_tag, 1);
    check("midrst_full", full, 0);
    tick();

    // Random traffic against the reference model.
    idle_inputs();
    rst_in = 1'b1;
    @(posedge clk_in);
    model_edge();
    #1;
    for (int n = 0; n < 3000; n++) begin
      rst_in         = ($urandom_range(0, 249) == 0);
      rdy_in         = ($urandom_range(0, 9) != 0);
      alloc_valid    = ($urandom_range(0, 2) != 0);
      alloc_rd       = 5'($urandom_range(0, 31));
      alloc_br       = ($urandom_range(0, 3) == 0);
      alloc_pred     = 1'($urandom_range(0, 1));
      alloc_alt_addr = $urandom;
      submit_valid   = ($urandom_range(0, 1) == 1);
      submit_tag     = pick_tag();
      submit_val     = $urandom;
      cdb_active     = ($urandom_range(0, 2) == 0);
      cdb_tag        = pick_tag();
      cdb_val        = $urandom;
      q1_tag         = pick_tag();
      q2_tag         = pick_tag();
      @(negedge clk_in);
      check_model();
      @(posedge clk_in);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
